// File: rtl/afifo_rx_drain_sched.sv
// afifo_rx_drain_sched
// Read-side scheduler that drains NUM_CH asynchronous-FIFO read ports into a
// single valid/ready stream in the read clock domain. Non-empty channels are
// served round-robin. Each grant reads a bounded burst of at most BURST_LEN
// words. A 2-entry skid buffer absorbs the FIFO's one-cycle registered read
// latency, so downstream backpressure never drops or repeats a word.
//
// Ports:
//   CLK         read-domain clock (rising edge)
//   RST         synchronous active-high reset
//   CH_R_EMPTY  per-channel FIFO empty flags
//   CH_REN      per-channel read enables, one-hot or zero
//   CH_R_DATA   per-channel registered read data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   OUT_VALID   OUT_DATA/OUT_CH valid
//   OUT_READY   downstream accept
//   OUT_DATA    drained word
//   OUT_CH      source channel of OUT_DATA
//   BUSY        scheduler active or skid buffer holding data
module afifo_rx_drain_sched #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH-1:0]            CH_R_EMPTY,
  output logic [NUM_CH-1:0]            CH_REN,
  input  logic [NUM_CH*DATA_WIDTH-1:0] CH_R_DATA,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [DATA_WIDTH-1:0]        OUT_DATA,
  output logic [CH_W-1:0]              OUT_CH,
  output logic                         BUSY
);

  localparam int                CNT_W   = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BURST_LEN);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, BURST, CLOSE} state_t;

  state_t                state, state_n;
  logic [CH_W-1:0]       rr_ptr, rr_ptr_n;
  logic [CH_W-1:0]       grant, grant_n;
  logic [CNT_W-1:0]      issue_cnt, issue_cnt_n;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] skid_data [2];
  logic [CH_W-1:0]       skid_ch   [2];
  logic [DATA_WIDTH-1:0] ch_data   [NUM_CH];

  logic                  pop;
  logic                  credit;
  logic                  grant_empty;
  logic                  issue;
  logic                  hit_found;
  logic [CH_W-1:0]       hit_ch;
  logic [CH_W-1:0]       scan_ch;
  int                    scan_idx;

  assign OUT_VALID   = (occ != 2'd0);
  assign OUT_DATA    = skid_data[rd_ptr];
  assign OUT_CH      = skid_ch[rd_ptr];
  assign pop         = OUT_VALID & OUT_READY;
  assign grant_empty = CH_R_EMPTY[grant];
  assign BUSY        = (state != IDLE) || (occ != 2'd0);

  // A new read is allowed only if the word it returns next cycle is sure to
  // have a skid slot: held words plus the word already in flight, less the
  // word leaving this cycle, must stay below the buffer depth.
  assign credit = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_data[k] = CH_R_DATA[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search: first non-empty channel at or above rr_ptr, wrapping.
  // The modulo keeps the wrap correct for non-power-of-2 channel counts.
  always_comb begin
    hit_found = 1'b0;
    hit_ch    = '0;
    scan_idx  = 0;
    scan_ch   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = (int'(rr_ptr) + i) % NUM_CH;
      scan_ch  = CH_W'(scan_idx);
      if (!hit_found && !CH_R_EMPTY[scan_ch]) begin
        hit_found = 1'b1;
        hit_ch    = scan_ch;
      end
    end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    rr_ptr_n    = rr_ptr;
    issue_cnt_n = issue_cnt;
    issue       = 1'b0;
    CH_REN      = '0;
    case (state)
      IDLE: begin
        if (hit_found) begin
          grant_n     = hit_ch;
          issue_cnt_n = '0;
          state_n     = BURST;
        end
      end
      BURST: begin
        issue = !grant_empty && (issue_cnt < CNT_MAX) && credit;
        if (issue) begin
          CH_REN[grant] = 1'b1;
          issue_cnt_n   = issue_cnt + 1'b1;
        end
        // An empty flag only ends the burst once a read could otherwise have
        // gone out; while stalled on credit the burst keeps its grant.
        if ((issue_cnt_n == CNT_MAX) || (grant_empty && credit)) begin
          state_n = CLOSE;
        end
      end
      CLOSE: begin
        // Hold the grant until the last read has been captured, since the
        // capture path selects its data and channel tag by grant.
        if (!inflight) begin
          rr_ptr_n = (grant == LAST_CH) ? '0 : grant + 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      issue_cnt <= '0;
      inflight  <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      grant     <= grant_n;
      issue_cnt <= issue_cnt_n;
      inflight  <= issue;
    end
  end

  // Skid buffer: the word returned by last cycle's read is appended at the
  // tail while the head may leave in the same cycle; occ tracks the net.
  always_ff @(posedge CLK) begin
    if (RST) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        skid_data[e] <= '0;
        skid_ch[e]   <= '0;
      end
    end else begin
      if (inflight) begin
        skid_data[wr_ptr] <= ch_data[grant];
        skid_ch[wr_ptr]   <= grant;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_afifo_rx_drain_sched.sv
// tb_afifo_rx_drain_sched
// Self-checking bench for afifo_rx_drain_sched. Each channel is modelled as a
// plain word queue that answers a read enable with its front word on the
// following cycle. Every word handed out by a modelled FIFO is queued in a
// scoreboard. The output stream must reproduce the scoreboard exactly, in
// order and tagged with the right channel. The bench also watches these rules:
//   - no read to an empty channel;
//   - read enables are one-hot or zero;
//   - reads never outrun the 2-word buffering;
//   - the output holds steady while stalled.
// Directed scenarios then pin down timing, burst cap and round-robin order.
module tb_afifo_rx_drain_sched;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int BL     = 4;
  localparam int CH_W   = 2;

  typedef logic [CH_W+DW-1:0] word_t;

  logic                   CLK;
  logic                   RST;
  logic [NUM_CH-1:0]      CH_R_EMPTY;
  logic [NUM_CH-1:0]      CH_REN;
  logic [NUM_CH*DW-1:0]   CH_R_DATA;
  logic                   OUT_VALID;
  logic                   OUT_READY;
  logic [DW-1:0]          OUT_DATA;
  logic [CH_W-1:0]        OUT_CH;
  logic                   BUSY;

  logic [DW-1:0] fifoQ [NUM_CH][$];
  word_t         expQ[$];
  int            obsCh[$];
  logic [DW-1:0] obsData[$];
  int            obsCyc[$];
  int            renCyc[$];
  int            renChQ[$];
  int            wantCh[$];
  logic [DW-1:0] wantData[$];

  int cyc           = 0;
  int numCompared   = 0;
  int numMismatched = 0;

  afifo_rx_drain_sched #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .BURST_LEN(BL), .CH_W(CH_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CH_R_EMPTY(CH_R_EMPTY), .CH_REN(CH_REN), .CH_R_DATA(CH_R_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_CH(OUT_CH), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pushWord(input int k, input logic [DW-1:0] w);
    fifoQ[k].push_back(w);
    CH_R_EMPTY[k] = 1'b0;
  endtask

  task automatic expectWord(input int k, input logic [DW-1:0] w);
    wantCh.push_back(k);
    wantData.push_back(w);
  endtask

  function automatic bit allFifoEmpty();
    bit r = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (fifoQ[k].size() != 0) r = 1'b0;
    end
    return r;
  endfunction

  // Monitor and FIFO model. Outputs are sampled at the falling edge; the FIFO
  // model answers the sampled read enables just after the rising edge.
  initial begin
    logic [NUM_CH-1:0] renS;
    logic              rstS;
    logic              popS;
    logic              stallPrev;
    logic [DW-1:0]     prevData;
    logic [CH_W-1:0]   prevCh;
    logic [DW-1:0]     w;
    word_t             e;
    int                ridx;
    stallPrev = 1'b0;
    prevData  = '0;
    prevCh    = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      renS = CH_REN;
      rstS = RST;
      popS = OUT_VALID && OUT_READY;
      if (!RST) begin
        checkOutput("ren_to_empty", 64'(CH_REN & CH_R_EMPTY), 64'(0));
        checkOutput("ren_onehot", 64'($countones(CH_REN) <= 1), 64'(1));
        if (CH_REN != '0) begin
          checkOutput("ren_credit", 64'((expQ.size() - int'(popS)) < 2), 64'(1));
          ridx = 0;
          for (int k = 0; k < NUM_CH; k++) if (CH_REN[k]) ridx = k;
          renCyc.push_back(cyc);
          renChQ.push_back(ridx);
        end
        if (stallPrev) begin
          checkOutput("stall_valid", 64'(OUT_VALID), 64'(1));
          checkOutput("stall_data", 64'(OUT_DATA), 64'(prevData));
          checkOutput("stall_ch", 64'(OUT_CH), 64'(prevCh));
        end
        if (popS) begin
          if (expQ.size() == 0) begin
            checkOutput("out_unexpected", 64'(OUT_VALID), 64'(0));
          end else begin
            e = expQ.pop_front();
            checkOutput("out_word", 64'({OUT_CH, OUT_DATA}), 64'(e));
          end
          obsCh.push_back(int'(OUT_CH));
          obsData.push_back(OUT_DATA);
          obsCyc.push_back(cyc);
        end
      end
      stallPrev = OUT_VALID && !OUT_READY && !RST;
      prevData  = OUT_DATA;
      prevCh    = OUT_CH;
      @(posedge CLK);
      #1;
      if (rstS) begin
        for (int k = 0; k < NUM_CH; k++) fifoQ[k].delete();
        expQ.delete();
        CH_R_EMPTY = '1;
        CH_R_DATA  = '0;
        stallPrev  = 1'b0;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (renS[k] && fifoQ[k].size() > 0) begin
            w = fifoQ[k].pop_front();
            CH_R_DATA[k*DW +: DW] = w;
            expQ.push_back({CH_W'(k), w});
          end
          CH_R_EMPTY[k] = (fifoQ[k].size() == 0);
        end
      end
    end
  end

  task automatic resetDut();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("rst_valid", 64'(OUT_VALID), 64'(0));
    checkOutput("rst_ren", 64'(CH_REN), 64'(0));
    checkOutput("rst_busy", 64'(BUSY), 64'(0));
    checkOutput("rst_data", 64'(OUT_DATA), 64'(0));
    checkOutput("rst_ch", 64'(OUT_CH), 64'(0));
    tick();
  endtask

  task automatic waitDrain(input int limit, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge CLK);
      done = (expQ.size() == 0) && allFifoEmpty() && !BUSY && !OUT_VALID;
    end
    checkOutput(tag, 64'(done), 64'(1));
    tick();
  endtask

  task automatic checkObs(input int base, input string tag);
    checkOutput({tag, "_count"}, 64'(obsCh.size() - base), 64'(wantCh.size()));
    for (int i = 0; i < wantCh.size() && base + i < obsCh.size(); i++) begin
      checkOutput({tag, "_ch"}, 64'(obsCh[base+i]), 64'(wantCh[i]));
      checkOutput({tag, "_data"}, 64'(obsData[base+i]), 64'(wantData[i]));
    end
    wantCh.delete();
    wantData.delete();
  endtask

  task automatic applyStimulus(input int nCycles);
    for (int n = 0; n < nCycles; n++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 7) == 0) pushWord(k, $urandom);
      end
      OUT_READY = ($urandom_range(0, 3) != 0);
      tick();
    end
    OUT_READY = 1'b1;
    waitDrain(4000, "rand_drain");
  endtask

  initial begin
    int c, ob, rb, n3;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    RST        = 1'b1;
    OUT_READY  = 1'b0;
    CH_R_EMPTY = '1;
    CH_R_DATA  = '0;

    // Single channel: three words on ch2, exact read timing and latency.
    resetDut();
    OUT_READY = 1'b1;
    c  = cyc + 1;
    ob = obsCh.size();
    rb = renCyc.size();
    for (int i = 0; i < 3; i++) begin
      pushWord(2, 32'hA000_0000 + i);
      expectWord(2, 32'hA000_0000 + i);
    end
    waitDrain(60, "t1_drain");
    checkObs(ob, "t1");
    checkOutput("t1_ren_count", 64'(renCyc.size() - rb), 64'(3));
    for (int i = 0; i < 3 && rb + i < renCyc.size(); i++) begin
      checkOutput("t1_ren_cycle", 64'(renCyc[rb+i]), 64'(c + 1 + i));
      checkOutput("t1_ren_ch", 64'(renChQ[rb+i]), 64'(2));
    end
    if (obsCyc.size() > ob) checkOutput("t1_latency", 64'(obsCyc[ob] - c), 64'(3));

    // rr_ptr now points at ch3: all channels loaded, service order 3,0,1,2.
    ob = obsCh.size();
    for (int k = 0; k < NUM_CH; k++) pushWord(k, 32'hB000_0000 + k);
    for (int j = 0; j < NUM_CH; j++) expectWord((3 + j) % NUM_CH, 32'hB000_0000 + ((3 + j) % NUM_CH));
    waitDrain(80, "t1_rr_drain");
    checkObs(ob, "t1_rr");

    // Burst cap and round-robin between two loaded channels.
    resetDut();
    OUT_READY = 1'b1;
    ob = obsCh.size();
    rb = renCyc.size();
    for (int i = 0; i < 6; i++) begin
      pushWord(0, 32'h0000_0100 + i);
      pushWord(1, 32'h0000_0200 + i);
    end
    for (int i = 0; i < 4; i++) expectWord(0, 32'h0000_0100 + i);
    for (int i = 0; i < 4; i++) expectWord(1, 32'h0000_0200 + i);
    for (int i = 4; i < 6; i++) expectWord(0, 32'h0000_0100 + i);
    for (int i = 4; i < 6; i++) expectWord(1, 32'h0000_0200 + i);
    waitDrain(200, "t2_drain");
    checkObs(ob, "t2");
    checkOutput("t2_ren_count", 64'(renCyc.size() - rb), 64'(12));
    if (renCyc.size() - rb >= 8) begin
      checkOutput("t2_gap_burst0", 64'(renCyc[rb+3] - renCyc[rb]), 64'(3));
      checkOutput("t2_gap_burst1", 64'(renCyc[rb+7] - renCyc[rb+4]), 64'(3));
    end

    // Backpressure with OUT_READY pattern 1,0,0,1.
    resetDut();
    ob = obsCh.size();
    for (int i = 0; i < 8; i++) begin
      pushWord(0, 32'h0000_0C00 + i);
      expectWord(0, 32'h0000_0C00 + i);
    end
    for (int i = 0; i < 120; i++) begin
      OUT_READY = pat[i % 4];
      tick();
    end
    OUT_READY = 1'b1;
    waitDrain(40, "t3_drain");
    checkObs(ob, "t3");

    // ch3 runs dry after 2 of 4 words; next grant rotates to ch0.
    resetDut();
    OUT_READY = 1'b1;
    ob = obsCh.size();
    rb = renCyc.size();
    pushWord(3, 32'h0000_0D30);
    pushWord(3, 32'h0000_0D31);
    tick();
    tick();
    pushWord(0, 32'h0000_0D00);
    pushWord(0, 32'h0000_0D01);
    expectWord(3, 32'h0000_0D30);
    expectWord(3, 32'h0000_0D31);
    expectWord(0, 32'h0000_0D00);
    expectWord(0, 32'h0000_0D01);
    waitDrain(80, "t4_drain");
    checkObs(ob, "t4");
    n3 = 0;
    for (int i = rb; i < renCyc.size(); i++) if (renChQ[i] == 3) n3++;
    checkOutput("t4_ch3_reads", 64'(n3), 64'(2));

    // Reset mid-burst with the skid buffer full; rr_ptr must restart at 0.
    OUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) pushWord(2, 32'h0000_0E20 + i);
    repeat (6) tick();
    @(negedge CLK);
    checkOutput("t5_valid_before", 64'(OUT_VALID), 64'(1));
    checkOutput("t5_busy_before", 64'(BUSY), 64'(1));
    tick();
    resetDut();
    OUT_READY = 1'b1;
    ob = obsCh.size();
    for (int k = 0; k < NUM_CH; k++) begin
      pushWord(k, 32'h0000_0F00 + k);
      expectWord(k, 32'h0000_0F00 + k);
    end
    waitDrain(80, "t5_drain");
    checkObs(ob, "t5_rr");

    // Randomized traffic and backpressure against the scoreboard.
    applyStimulus(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
